exe_stage: RTL and testbench

Execute stage of the 5-stage ARM pipeline. It consumes the registered decode bundle, generates the second ALU operand, and computes the ALU result and branch target. It also owns the NZCV status register. MUL instructions run on an iterative shift-add multiplier, and the block stalls the upstream pipeline until the product is ready.

---
 rtl/arm_pkg.sv | 45 ++++
 rtl/val2_generator.sv | 42 ++++
 rtl/exe_stage.sv | 177 +++++++++++++++++
 tb/tb_exe_stage.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// +----------------------------------------------------------------------+
// | arm_pkg : shared opcodes, flag indices, shift codes, MUL FSM states  |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

package arm_pkg;

  localparam logic [3:0] c_EXE_NOP = 4'b0000;
  localparam logic [3:0] c_EXE_MOV = 4'b0001;
  localparam logic [3:0] c_EXE_MVN = 4'b1001;
  localparam logic [3:0] c_EXE_ADD = 4'b0010;
  localparam logic [3:0] c_EXE_ADC = 4'b0011;
  localparam logic [3:0] c_EXE_SUB = 4'b0100;
  localparam logic [3:0] c_EXE_SBC = 4'b0101;
  localparam logic [3:0] c_EXE_AND = 4'b0110;
  localparam logic [3:0] c_EXE_ORR = 4'b0111;
  localparam logic [3:0] c_EXE_EOR = 4'b1000;
  localparam logic [3:0] c_EXE_MUL = 4'b1111;

  localparam int c_FLAG_N = 3;
  localparam int c_FLAG_Z = 2;
  localparam int c_FLAG_C = 1;
  localparam int c_FLAG_V = 0;

  localparam logic [1:0] c_SHIFT_LSL = 2'b00;
  localparam logic [1:0] c_SHIFT_LSR = 2'b01;
  localparam logic [1:0] c_SHIFT_ASR = 2'b10;
  localparam logic [1:0] c_SHIFT_ROR = 2'b11;

  typedef enum logic [1:0] {
    c_MUL_IDLE = 2'd0,
    c_MUL_BUSY = 2'd1,
    c_MUL_DONE = 2'd2
  } mul_state_e;

  function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] n);
    logic [63:0] dbl;
    dbl = {v, v} >> n;
    return dbl[31:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/val2_generator.sv
// +----------------------------------------------------------------------+
// | val2_generator : second ALU operand (offset, rotated imm, shifted Rm)|
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module val2_generator
  import arm_pkg::*;
(
  input  logic [31:0] Val_Rm_i,
  input  logic        imm_i,
  input  logic [11:0] Shift_operand_i,
  input  logic        mem_access_i,
  output logic [31:0] Val2_o
);

  logic [4:0]         w_shamt;
  logic signed [31:0] w_asr;

  assign w_shamt = Shift_operand_i[11:7];
  assign w_asr   = $signed(Val_Rm_i) >>> w_shamt;

  // A zero shift amount is the identity for every shift type here.
  always_comb begin
    Val2_o = Val_Rm_i;
    if (mem_access_i) begin
      Val2_o = {20'd0, Shift_operand_i};
    end else if (imm_i) begin
      Val2_o = ror32({24'd0, Shift_operand_i[7:0]}, {Shift_operand_i[11:8], 1'b0});
    end else begin
      case (Shift_operand_i[6:5])
        c_SHIFT_LSL: Val2_o = Val_Rm_i << w_shamt;
        c_SHIFT_LSR: Val2_o = Val_Rm_i >> w_shamt;
        c_SHIFT_ASR: Val2_o = w_asr;
        default:     Val2_o = ror32(Val_Rm_i, w_shamt);
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/exe_stage.sv
// +----------------------------------------------------------------------+
// | exe_stage : ALU, branch target, NZCV and iterative shift-add MUL     |
// | Option   : MUL_EARLY_TERM_EN ends MUL once remaining multiplier is 0 |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module exe_stage
  import arm_pkg::*;
#(
  parameter int MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        WB_EN,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic        B,
  input  logic        S,
  input  logic [3:0]  EXE_CMD,
  input  logic [31:0] PC,
  input  logic [31:0] Val_Rn,
  input  logic [31:0] Val_Rm,
  input  logic        imm,
  input  logic [11:0] Shift_operand,
  input  logic [23:0] Signed_imm_24,
  output logic [31:0] ALU_Res,
  output logic [31:0] Br_Addr,
  output logic [3:0]  status,
  output logic        stall
);

  localparam int                 c_CNT_W    = $clog2(MUL_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(MUL_CYCLES - 1);

  mul_state_e         state_q, state_d;
  logic [31:0]        mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [c_CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]         status_q, status_d;

  logic [31:0] w_val2, w_res, w_opb;
  logic [32:0] w_sum;
  logic        w_arith, w_logic, w_mul, w_v, w_last, w_skip, w_upd;
  logic        w_unused;

  assign w_unused = WB_EN;

  val2_generator u_val2 (
    .Val_Rm_i        (Val_Rm),
    .imm_i           (imm),
    .Shift_operand_i (Shift_operand),
    .mem_access_i    (MEM_R_EN | MEM_W_EN),
    .Val2_o          (w_val2)
  );

  // Subtraction is Rn + ~Val2 + cin, so the carry-out is already NOT borrow.
  always_comb begin
    w_sum   = 33'd0;
    w_opb   = w_val2;
    w_res   = 32'd0;
    w_arith = 1'b0;
    w_logic = 1'b0;
    w_mul   = 1'b0;
    case (EXE_CMD)
      c_EXE_MOV: begin w_res = w_val2;          w_logic = 1'b1; end
      c_EXE_MVN: begin w_res = ~w_val2;         w_logic = 1'b1; end
      c_EXE_AND: begin w_res = Val_Rn & w_val2; w_logic = 1'b1; end
      c_EXE_ORR: begin w_res = Val_Rn | w_val2; w_logic = 1'b1; end
      c_EXE_EOR: begin w_res = Val_Rn ^ w_val2; w_logic = 1'b1; end
      c_EXE_ADD: begin
        w_sum   = {1'b0, Val_Rn} + {1'b0, w_opb};
        w_arith = 1'b1;
      end
      c_EXE_ADC: begin
        w_sum   = {1'b0, Val_Rn} + {1'b0, w_opb} + {32'd0, status_q[c_FLAG_C]};
        w_arith = 1'b1;
      end
      c_EXE_SUB: begin
        w_opb   = ~w_val2;
        w_sum   = {1'b0, Val_Rn} + {1'b0, w_opb} + 33'd1;
        w_arith = 1'b1;
      end
      c_EXE_SBC: begin
        w_opb   = ~w_val2;
        w_sum   = {1'b0, Val_Rn} + {1'b0, w_opb} + {32'd0, status_q[c_FLAG_C]};
        w_arith = 1'b1;
      end
      c_EXE_MUL: begin w_res = acc_q; w_mul = 1'b1; end
      default: ;
    endcase
    if (w_arith) w_res = w_sum[31:0];
  end

  assign w_v = (Val_Rn[31] == w_opb[31]) && (w_sum[31] != Val_Rn[31]);

`ifdef MUL_EARLY_TERM_EN
  assign w_last = (cnt_q == c_LAST_CNT) || (mplier_q[31:1] == 31'd0);
  assign w_skip = (Val_Rm == 32'd0);
`else
  assign w_last = (cnt_q == c_LAST_CNT);
  assign w_skip = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    stall    = 1'b0;
    case (state_q)
      c_MUL_IDLE: begin
        if (w_mul) begin
          stall    = 1'b1;
          mcand_d  = Val_Rn;
          mplier_d = Val_Rm;
          acc_d    = 32'd0;
          cnt_d    = '0;
          state_d  = w_skip ? c_MUL_DONE : c_MUL_BUSY;
        end
      end
      c_MUL_BUSY: begin
        stall    = 1'b1;
        acc_d    = mplier_q[0] ? acc_q + mcand_q : acc_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (w_last) state_d = c_MUL_DONE;
      end
      default: state_d = c_MUL_IDLE;
    endcase
    if (flush) begin
      state_d = c_MUL_IDLE;
      stall   = 1'b0;
    end
  end

  assign w_upd = S && !stall && !flush && !B;

  always_comb begin
    status_d = status_q;
    if (w_upd) begin
      if (w_arith) begin
        status_d = {w_res[31], (w_res == 32'd0), w_sum[32], w_v};
      end else if (w_logic || (w_mul && state_q == c_MUL_DONE)) begin
        status_d[c_FLAG_N] = w_res[31];
        status_d[c_FLAG_Z] = (w_res == 32'd0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= c_MUL_IDLE;
      mcand_q  <= 32'd0;
      mplier_q <= 32'd0;
      acc_q    <= 32'd0;
      cnt_q    <= '0;
      status_q <= 4'b0000;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      status_q <= status_d;
    end
  end

  assign ALU_Res = w_res;
  assign Br_Addr = PC + {{6{Signed_imm_24[23]}}, Signed_imm_24, 2'b00};
  assign status  = status_q;

endmodule

`default_nettype wire

// File: tb/tb_exe_stage.sv
// +----------------------------------------------------------------------+
// | tb_exe_stage : directed vectors with a behavioural execute-stage model|
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_exe_stage;

  localparam int MUL_CYCLES = 32;
  localparam logic [3:0] OP_NOP = 4'b0000, OP_MOV = 4'b0001, OP_MVN = 4'b1001,
                         OP_ADD = 4'b0010, OP_ADC = 4'b0011, OP_SUB = 4'b0100,
                         OP_SBC = 4'b0101, OP_AND = 4'b0110, OP_ORR = 4'b0111,
                         OP_EOR = 4'b1000, OP_MUL = 4'b1111;

  logic        clk = 1'b0;
  logic        rst, flush, WB_EN, MEM_R_EN, MEM_W_EN, B, S, imm;
  logic [3:0]  EXE_CMD;
  logic [31:0] PC, Val_Rn, Val_Rm;
  logic [11:0] Shift_operand;
  logic [23:0] Signed_imm_24;
  logic [31:0] ALU_Res, Br_Addr;
  logic [3:0]  status;
  logic        stall;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  exe_stage #(.MUL_CYCLES(MUL_CYCLES)) dut (
    .clk(clk), .rst(rst), .flush(flush), .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN),
    .MEM_W_EN(MEM_W_EN), .B(B), .S(S), .EXE_CMD(EXE_CMD), .PC(PC),
    .Val_Rn(Val_Rn), .Val_Rm(Val_Rm), .imm(imm), .Shift_operand(Shift_operand),
    .Signed_imm_24(Signed_imm_24), .ALU_Res(ALU_Res), .Br_Addr(Br_Addr),
    .status(status), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [3:0]  m_st = 4'd0;
  logic [31:0] m_prod = 32'd0;
  int          m_left = 0;
  bit          m_busy = 1'b0, m_done = 1'b0;

  function automatic int m_iters(input logic [31:0] rm);
`ifdef MUL_EARLY_TERM_EN
    for (int i = 31; i >= 0; i--) if (rm[i]) return i + 1;
    return 0;
`else
    return MUL_CYCLES;
`endif
  endfunction

  function automatic logic [31:0] m_ror(input logic [31:0] v, input int n);
    int k;
    k = n % 32;
    if (k == 0) return v;
    return (v >> k) | (v << (32 - k));
  endfunction

  function automatic logic [31:0] m_val2();
    logic signed [31:0] sv;
    int n;
    if (MEM_R_EN || MEM_W_EN) return {20'd0, Shift_operand};
    if (imm) return m_ror({24'd0, Shift_operand[7:0]}, 2 * int'(Shift_operand[11:8]));
    n  = int'(Shift_operand[11:7]);
    sv = $signed(Val_Rm) >>> n;
    case (Shift_operand[6:5])
      2'b00:   return Val_Rm << n;
      2'b01:   return Val_Rm >> n;
      2'b10:   return sv;
      default: return m_ror(Val_Rm, n);
    endcase
  endfunction

  // Arithmetic from plain integer maths: unsigned range gives C, signed range gives V.
  task automatic m_alu(output logic [31:0] res, output logic [3:0] nst);
    longint ua, ub, u, sa, sb, s;
    logic [31:0] b;
    bit c, v, ar, lg;
    int cin;
    b   = m_val2();
    ua  = longint'(Val_Rn);
    ub  = longint'(b);
    sa  = longint'($signed(Val_Rn));
    sb  = longint'($signed(b));
    cin = int'(m_st[1]);
    ar  = 1'b0; lg = 1'b0; res = 32'd0; c = 1'b0; u = 0; s = 0;
    case (EXE_CMD)
      OP_ADD: begin u = ua + ub;       s = sa + sb;       c = (u > 64'hFFFFFFFF); ar = 1; end
      OP_ADC: begin u = ua + ub + cin; s = sa + sb + cin; c = (u > 64'hFFFFFFFF); ar = 1; end
      OP_SUB: begin u = ua - ub;       s = sa - sb;       c = (ua >= ub);         ar = 1; end
      OP_SBC: begin u = ua - ub - (1 - cin); s = sa - sb - (1 - cin);
                    c = (ua >= ub + (1 - cin)); ar = 1; end
      OP_MOV: begin res = b;            lg = 1; end
      OP_MVN: begin res = ~b;           lg = 1; end
      OP_AND: begin res = Val_Rn & b;   lg = 1; end
      OP_ORR: begin res = Val_Rn | b;   lg = 1; end
      OP_EOR: begin res = Val_Rn ^ b;   lg = 1; end
      default: ;
    endcase
    v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    nst = m_st;
    if (ar) begin
      res = u[31:0];
      nst = {res[31], res == 32'd0, c, v};
    end else if (lg) begin
      nst[3] = res[31];
      nst[2] = (res == 32'd0);
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] er, eb;
    logic [3:0]  nst;
    logic        es;
    int          off;
    m_alu(er, nst);
    if (chk_en && rst) begin
      if (flush)       es = 1'b0;
      else if (m_done) es = 1'b0;
      else if (m_busy) es = 1'b1;
      else             es = (EXE_CMD == OP_MUL);
      off = int'($signed(Signed_imm_24));
      eb  = PC + 32'(off * 4);
      chk("stall", {31'd0, stall}, {31'd0, es});
      chk("status", {28'd0, status}, {28'd0, m_st});
      chk("br_addr", Br_Addr, eb);
      if (EXE_CMD != OP_MUL)       chk("alu_res", ALU_Res, er);
      else if (m_done && !flush)   chk("mul_res", ALU_Res, m_prod);
    end
    if (!rst) begin
      m_st = 4'd0; m_busy = 0; m_done = 0; m_left = 0;
    end else if (flush) begin
      m_busy = 0; m_done = 0;
    end else if (m_done) begin
      m_done = 0;
      if (S && !B) begin m_st[3] = m_prod[31]; m_st[2] = (m_prod == 32'd0); end
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin m_busy = 0; m_done = 1; end
    end else if (EXE_CMD == OP_MUL) begin
      m_prod = Val_Rn * Val_Rm;
      m_left = m_iters(Val_Rm);
      if (m_left == 0) m_done = 1; else m_busy = 1;
    end else if (S && !B) begin
      m_st = nst;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_op(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                        input logic im, input logic [11:0] so, input logic s_b);
    EXE_CMD = cmd; Val_Rn = rn; Val_Rm = rm; imm = im; Shift_operand = so; S = s_b;
    WB_EN = 1'b1; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; B = 1'b0; flush = 1'b0;
  endtask

  task automatic run_mul(input logic [31:0] rn, input logic [31:0] rm, input logic s_b,
                         input logic [31:0] exp_prod);
    int n;
    set_op(OP_MUL, rn, rm, 1'b0, 12'd0, s_b);
    n = 0;
    #1;
    while (stall === 1'b1 && n < 60) begin
      n++;
      tick();
    end
    chk("mul_stall_cycles", n, m_iters(rm) + 1);
    chk("mul_product", ALU_Res, exp_prod);
    tick();
    set_op(OP_NOP, 0, 0, 1'b0, 12'd0, 1'b0);
    #1;
    chk("mul_no_restart", {31'd0, stall}, 32'd0);
  endtask

  initial begin
    logic [3:0] saved;
    PC = 32'h100; Signed_imm_24 = 24'h000010;
    set_op(OP_NOP, 0, 0, 1'b0, 12'd0, 1'b0);
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1; chk_en = 1'b1;
    #1;
    chk("reset_status", {28'd0, status}, 32'd0);
    chk("reset_stall", {31'd0, stall}, 32'd0);

    set_op(OP_ADD, 32'h7FFFFFFF, 0, 1'b1, 12'h001, 1'b1); #1;
    chk("add_ovf_res", ALU_Res, 32'h80000000);
    tick(); chk("add_ovf_status", {28'd0, status}, 32'h9);

    set_op(OP_SUB, 5, 5, 1'b0, 12'h000, 1'b1); WB_EN = 1'b0; #1;
    chk("cmp_res", ALU_Res, 32'd0);
    tick(); chk("cmp_status", {28'd0, status}, 32'h6);

    set_op(OP_MOV, 0, 0, 1'b1, 12'h4FF, 1'b0); #1;
    chk("mov_rot_imm", ALU_Res, 32'hFF000000);
    set_op(OP_MOV, 0, 32'h80000000, 1'b0, 12'h240, 1'b0); #1;
    chk("mov_asr4", ALU_Res, 32'hF8000000);
    set_op(OP_EOR, 32'h0F0F0F0F, 32'h12345678, 1'b0, 12'h0E0, 1'b1); tick();
    set_op(OP_MVN, 0, 32'h000000F0, 1'b0, 12'h260, 1'b1); tick();
    set_op(OP_ORR, 32'h1, 32'h80000001, 1'b0, 12'h0A0, 1'b0); tick();

    set_op(OP_SUB, 0, 1, 1'b0, 12'h000, 1'b1); #1;
    chk("sub_borrow_res", ALU_Res, 32'hFFFFFFFF);
    tick(); chk("sub_borrow_status", {28'd0, status}, 32'h8);
    set_op(OP_ADC, 1, 0, 1'b1, 12'h001, 1'b1); #1;
    chk("adc_c0", ALU_Res, 32'd2);
    tick();
    set_op(OP_SBC, 10, 0, 1'b1, 12'h003, 1'b1); #1;
    chk("sbc_c0", ALU_Res, 32'd6);
    tick(); chk("sbc_status", {28'd0, status}, 32'h2);
    set_op(OP_ADC, 1, 0, 1'b1, 12'h001, 1'b0); #1;
    chk("adc_c1", ALU_Res, 32'd3);
    set_op(OP_SUB, 32'h80000000, 1, 1'b0, 12'h000, 1'b1); tick();
    set_op(OP_ADD, 32'hFFFFFFFF, 1, 1'b0, 12'h000, 1'b1); tick();
    set_op(OP_AND, 32'hF0, 32'h0F, 1'b0, 12'h000, 1'b1); B = 1'b1; tick();

    PC = 32'h100; Signed_imm_24 = 24'hFFFFFE; #1;
    chk("br_addr_neg", Br_Addr, 32'hF8);

    set_op(OP_ADD, 32'h1000, 0, 1'b1, 12'hFFF, 1'b0); MEM_R_EN = 1'b1; #1;
    chk("ldr_offset", ALU_Res, 32'h1FFF);
    tick();

    run_mul(1234, 5678, 1'b1, 32'd7006652);
    run_mul(32'hFFFFFFFD, 7, 1'b0, 32'hFFFFFFEB);
    run_mul(32'h12345678, 0, 1'b1, 32'd0);
    chk("mul_zero_z", {31'd0, status[2]}, 32'd1);

    set_op(OP_MUL, 3, 4, 1'b0, 12'd0, 1'b1); flush = 1'b1; #1;
    chk("flush_idle_stall", {31'd0, stall}, 32'd0);
    tick(); set_op(OP_NOP, 0, 0, 1'b0, 12'd0, 1'b0); #1;
    chk("flush_idle_nostart", {31'd0, stall}, 32'd0);

    saved = status;
    set_op(OP_MUL, 3, 32'hFFFF, 1'b0, 12'd0, 1'b1);
    repeat (11) tick();
    flush = 1'b1; #1;
    chk("flush_busy_stall", {31'd0, stall}, 32'd0);
    tick(); set_op(OP_NOP, 0, 0, 1'b0, 12'd0, 1'b0); #1;
    chk("flush_busy_after", {31'd0, stall}, 32'd0);
    chk("flush_status_kept", {28'd0, status}, {28'd0, saved});
    run_mul(100, 200, 1'b1, 32'd20000);

    set_op(OP_MUL, 7, 9, 1'b0, 12'd0, 1'b1);
    repeat (5) tick();
    rst = 1'b0; tick();
    rst = 1'b1; set_op(OP_NOP, 0, 0, 1'b0, 12'd0, 1'b0); #1;
    chk("midmul_reset_status", {28'd0, status}, 32'd0);
    chk("midmul_reset_stall", {31'd0, stall}, 32'd0);
    set_op(OP_ADD, 2, 3, 1'b0, 12'h000, 1'b1); tick();
    set_op(OP_NOP, 0, 0, 1'b0, 12'd0, 1'b0); tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
